servo_pwm_array: RTL and testbench

- Parametrised multi-channel successor to the single-channel servo driver.
- Drives NUM_CH servo outputs from one shared 20 ms frame counter.
- Per-channel duty codes are written through a simple strobe interface and held in pending registers.
- Pending codes are applied only at frame boundaries, so no pulse is ever truncated or glitched.
- Sits between the register/IO block and the board servo pins.

---
 rtl/servo_pwm_array.sv | 121 ++++++++++++
 tb/tb_servo_pwm_array.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_array.sv
// rtl/servo_pwm_array.sv - multi-channel servo PWM driven from one shared frame counter
// Optional: define SERVO_ARRAY_SLEW_LIMIT_EN to rate-limit duty-code changes per frame.
module servo_pwm_array #(
    parameter int NUM_CH       = 4,
    parameter int DUTY_W       = 10,
    parameter int SYS_FREQ_MHZ = 25,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_PULSE_US = 1000,
    parameter int MAX_PULSE_US = 2000,
    parameter int SLEW_STEP    = 8,
    localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk25mhz,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CHW-1:0]    wr_ch,
    input  logic [DUTY_W-1:0] wr_duty,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic [NUM_CH-1:0] servo_out,
    output logic              frame_start,
    output logic [NUM_CH-1:0] pending
);

    localparam int PERIOD_TICKS = PERIOD_US * SYS_FREQ_MHZ;
    localparam int MIN_TICKS    = MIN_PULSE_US * SYS_FREQ_MHZ;
    localparam int SPAN_TICKS   = (MAX_PULSE_US - MIN_PULSE_US) * SYS_FREQ_MHZ;
    localparam int TW           = $clog2(PERIOD_TICKS + 1);
    localparam int PW           = DUTY_W + $clog2(SPAN_TICKS + 1);
`ifdef SERVO_ARRAY_SLEW_LIMIT_EN
    localparam int STEP_LIM     = SLEW_STEP;
`else
    // A step wider than the whole code range makes every update a direct jump.
    localparam int STEP_LIM     = SLEW_STEP + (1 << DUTY_W);
`endif

    logic [TW-1:0]     cnt_q, cnt_d;
    logic              frame_start_q, frame_start_d;
    logic [NUM_CH-1:0] servo_q, servo_d;
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [DUTY_W-1:0] pend_code_q [NUM_CH];
    logic [DUTY_W-1:0] pend_code_d [NUM_CH];
    logic [DUTY_W-1:0] act_code_q  [NUM_CH];
    logic [DUTY_W-1:0] act_code_d  [NUM_CH];
    logic [PW-1:0]     prod        [NUM_CH];
    logic [TW-1:0]     act_ticks   [NUM_CH];
    int                diff        [NUM_CH];
    logic              boundary;

    // Full-width product before the shift keeps the span exact.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            prod[i]      = PW'(act_code_q[i]) * PW'(SPAN_TICKS);
            act_ticks[i] = TW'(MIN_TICKS) + TW'(prod[i] >> DUTY_W);
        end
    end

    always_comb begin
        boundary      = (cnt_q == TW'(PERIOD_TICKS - 1));
        cnt_d         = boundary ? '0 : cnt_q + TW'(1);
        frame_start_d = (cnt_q == '0);
        // A channel may only start driving at counter 0; any disable kills it until then.
        run_d         = (cnt_q == '0) ? ch_enable : (run_q & ch_enable);
        for (int i = 0; i < NUM_CH; i++) begin
            servo_d[i] = run_d[i] && (cnt_q < act_ticks[i]);
        end
    end

    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_CH; i++) begin
            pend_code_d[i] = pend_code_q[i];
            act_code_d[i]  = act_code_q[i];
            diff[i]        = int'(pend_code_q[i]) - int'(act_code_q[i]);
            if (boundary && pending_q[i]) begin
                if (diff[i] > STEP_LIM) begin
                    act_code_d[i] = DUTY_W'(int'(act_code_q[i]) + STEP_LIM);
                end else if (diff[i] < -STEP_LIM) begin
                    act_code_d[i] = DUTY_W'(int'(act_code_q[i]) - STEP_LIM);
                end else begin
                    act_code_d[i] = pend_code_q[i];
                end
                pending_d[i] = (diff[i] > STEP_LIM) || (diff[i] < -STEP_LIM);
            end
            // A write in the boundary cycle lands after the transfer above.
            if (wr_en && (int'(wr_ch) == i)) begin
                pend_code_d[i] = wr_duty;
                pending_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk25mhz or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
            servo_q       <= '0;
            run_q         <= '0;
            pending_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_code_q[i] <= '0;
                act_code_q[i]  <= '0;
            end
        end else begin
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
            servo_q       <= servo_d;
            run_q         <= run_d;
            pending_q     <= pending_d;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_code_q[i] <= pend_code_d[i];
                act_code_q[i]  <= act_code_d[i];
            end
        end
    end

    assign servo_out   = servo_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_servo_pwm_array.sv
// tb/tb_servo_pwm_array.sv - scoreboard bench for servo_pwm_array with a shortened frame
module tb_servo_pwm_array;

    localparam int NCH = 3;
    localparam int DW  = 10;
    localparam int PT  = 2000;

    logic           clk = 1'b0;
    logic           reset;
    logic           wr_en;
    logic [1:0]     wr_ch;
    logic [DW-1:0]  wr_duty;
    logic [NCH-1:0] ch_enable;
    logic [NCH-1:0] servo_out;
    logic           frame_start;
    logic [NCH-1:0] pending;

    servo_pwm_array #(
        .NUM_CH(NCH), .DUTY_W(DW), .SYS_FREQ_MHZ(1), .PERIOD_US(PT),
        .MIN_PULSE_US(100), .MAX_PULSE_US(200), .SLEW_STEP(8)
    ) dut (
        .clk25mhz(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_duty(wr_duty), .ch_enable(ch_enable), .servo_out(servo_out),
        .frame_start(frame_start), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    frame;
        int    ch;
        int    width;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cur      = 0;
    int   started  = 0;
    int   acc [NCH];
    int   pos      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Pulse widths of one frame, recorded against the frame now in progress.
    task automatic push(input string tag, input int w0, input int w1, input int w2);
        int w [NCH];
        w[0] = w0; w[1] = w1; w[2] = w2;
        for (int c = 0; c < NCH; c++) begin
            exp_q.push_back('{$sformatf("%s_f%0d_ch%0d", tag, cur, c), cur, c, w[c]});
        end
    endtask

    // Measures each frame's high-cycle count and retires the matching expectations.
    always @(negedge clk) begin
        if (!reset) begin
            started = 0;
            cur     = 0;
            for (int c = 0; c < NCH; c++) acc[c] = 0;
        end else if (frame_start) begin
            if (started != 0) begin
                while (exp_q.size() > 0 && exp_q[0].frame == cur) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(e.tag, acc[e.ch], e.width);
                end
                cur++;
            end
            started = 1;
            for (int c = 0; c < NCH; c++) acc[c] = int'(servo_out[c]);
        end else begin
            for (int c = 0; c < NCH; c++) acc[c] += int'(servo_out[c]);
        end
    end

    task automatic next_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 2 * PT + 8);
        chk("frame_start_seen", frame_start, 1);
        pos = 0;
    endtask

    // Leaves the bench at the negedge just before the edge where the counter equals c.
    task automatic at_cnt(input int c);
        while (pos < c - 1) begin
            @(negedge clk);
            pos++;
        end
    endtask

    task automatic write_now(input int ch, input int d);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_duty = DW'(d);
        @(negedge clk);
        wr_en   = 1'b0;
        pos++;
    endtask

    initial begin
        reset     = 1'b0;
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_duty   = '0;
        ch_enable = '1;
        repeat (3) @(negedge clk);
        chk("reset_servo_out", servo_out, 0);
        chk("reset_frame_start", frame_start, 0);
        chk("reset_pending", pending, 0);
        reset = 1'b1;

        next_frame(); at_cnt(10);
        push("base", 100, 100, 100);

        next_frame(); at_cnt(10);
        push("ch2_wr_frame", 100, 100, 100);
        at_cnt(500); write_now(2, 512);
        chk("pending_after_wr_ch2", pending, 3'b100);

        next_frame(); at_cnt(2);
        chk("pending_clear_ch2", pending, 0);
        push("ch2_applied", 100, 100, 150);
        at_cnt(300); write_now(0, 1023);
        at_cnt(400); write_now(0, 0);
        chk("pending_ch0_twice", pending, 3'b001);

        next_frame(); at_cnt(2);
        push("last_write_wins", 100, 100, 150);
        at_cnt(300); write_now(0, 1023);

        next_frame(); at_cnt(2);
        push("code_1023", 199, 100, 150);
        at_cnt(PT - 2); write_now(1, 512);
        write_now(2, 0);
        chk("pending_boundary_wr", pending, 3'b100);

        next_frame(); at_cnt(2);
        push("enable_cut", 199, 40, 150);
        at_cnt(40); ch_enable = 3'b101;
        at_cnt(60); ch_enable = 3'b111;
        chk("ch1_off_after_reenable", servo_out[1], 0);
        at_cnt(300); write_now(3, 5);
        chk("pending_invalid_ch", pending, 3'b100);

        next_frame(); at_cnt(2);
        chk("pending_clear_late", pending, 0);
        push("boundary_applied", 199, 150, 100);

        next_frame(); at_cnt(50);
        chk("pre_reset_high", servo_out, 3'b111);
        reset = 1'b0;
        #1;
        chk("midreset_servo_out", servo_out, 0);
        chk("midreset_frame_start", frame_start, 0);
        chk("midreset_pending", pending, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        next_frame(); at_cnt(10);
        push("post_reset", 100, 100, 100);
        next_frame(); at_cnt(10);
        push("post_reset", 100, 100, 100);
        next_frame();
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
